// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI master.
package spi_pkg;

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} spi_state_t;

    // Edge counter must hold 0..2*DATA_W.
    function automatic int ecnt_w(input int dw);
        return $clog2(2 * dw + 1);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: single-cycle tick every CLK_DIV enabled cycles.
module spi_clk_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == TOP) ? '0 : cnt + 1'b1;
    end

    assign tick = en && (cnt == TOP);

endmodule

// File: rtl/spi_master.sv
// Parametrised full-duplex SPI master; sclk is a registered output of clk.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int CLK_DIV   = 50,
    parameter int LSB_FIRST = 1,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    input  logic              miso,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic              sclk,
    output logic              cs,
    output logic              mosi
);
    localparam int EW = ecnt_w(DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);
    localparam logic SCLK_IDLE = 1'(CPOL);

    spi_state_t state, state_nx;

    logic              tick, accept, in_shift, odd, last, sample, drive;
    logic [EW-1:0]     edge_cnt, edge_n;
    logic [DATA_W-1:0] tx_sr, rx_sr;

    function automatic logic tx_bit(input logic [DATA_W-1:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] v);
        return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
    endfunction

    // Fill from the end opposite the first bit so dout lines up with din.
    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] v, input logic b);
        return (LSB_FIRST != 0) ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .clr  (accept),
        .tick (tick)
    );

    assign accept   = newd && ready;
    assign in_shift = (state == LEAD) || (state == SHIFT);
    assign edge_n   = edge_cnt + 1'b1;
    assign odd      = edge_n[0];
    assign last     = (edge_n == LAST_EDGE);
    // The LEAD exit tick is itself sclk edge 1.
    assign sample   = tick && in_shift && ((CPHA != 0) ? !odd : odd);
    assign drive    = tick && in_shift && ((CPHA != 0) ? odd : (!odd && !last));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)        state_nx = LEAD;
            LEAD:    if (tick)          state_nx = SHIFT;
            SHIFT:   if (tick && last)  state_nx = TRAIL;
            TRAIL:   if (tick)          state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        cs    = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk     <= SCLK_IDLE;
            mosi     <= 1'b0;
            done     <= 1'b0;
            dout     <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            edge_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // CPHA=0 puts the first bit on the wire before the first edge.
                tx_sr    <= (CPHA != 0) ? din : tx_shift(din);
                mosi     <= (CPHA != 0) ? 1'b0 : tx_bit(din);
                rx_sr    <= '0;
                edge_cnt <= '0;
                sclk     <= SCLK_IDLE;
            end else begin
                if (tick && in_shift) begin
                    sclk     <= ~sclk;
                    edge_cnt <= edge_n;
                end
                if (drive) begin
                    mosi  <= tx_bit(tx_sr);
                    tx_sr <= tx_shift(tx_sr);
                end
                if (sample)
                    rx_sr <= rx_shift(rx_sr, miso);
                if (tick && state == TRAIL) begin
                    mosi <= 1'b0;
                    done <= 1'b1;
                    dout <= rx_sr;
                end
            end
        end
    end

endmodule
